// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots the systolic array result bus on a capture
// strobe and streams the N results out one per cycle over valid/ready,
// tagged with the flattened PE index. Captures that arrive mid-drain are
// dropped and counted (sticky OVF, saturating DROP_CNT).
module sa_result_drain #(
    parameter int WIDTH = 8,
    parameter int HPE   = 4,
    parameter int VPE   = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [2*WIDTH*HPE*VPE-1:0]        Y_IN,
    input  logic                              CAP,
    input  logic                              CLR_OVF,
    output logic [2*WIDTH-1:0]                OUT_DATA,
    output logic [$clog2(HPE*VPE)-1:0]        OUT_IDX,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic                              OUT_LAST,
    output logic                              BUSY,
    output logic                              OVF,
    output logic [7:0]                        DROP_CNT
);

    localparam int N  = HPE * VPE;
    localparam int DW = 2 * WIDTH;
    localparam int IW = $clog2(N);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [0:0]            state;
    logic [IW-1:0]         idx;
    logic [N-1:0][DW-1:0]  snap;
    logic [DW-1:0]         elem [N];
    logic                  busy;
    logic                  at_last;
    logic                  xfer;
    logic                  take;
    logic                  drop;

    // Element 0 is the MSB word of the bus, so it lands in snap[N-1].
    for (genvar p = 0; p < N; p++) begin : g_elem
        assign elem[p] = snap[N-1-p];
    end

    assign busy    = (state == S_DRAIN);
    assign at_last = (idx == LAST_IDX);
    assign xfer    = busy && OUT_READY;
    // A capture is accepted when idle, or when the final element leaves on
    // this very cycle (back-to-back, no bubble); otherwise it is dropped.
    assign take    = CAP && (!busy || (xfer && at_last));
    assign drop    = CAP && busy && !(xfer && at_last);

    // Drain sequencer: snapshot capture, index advance, return to idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            idx   <= '0;
            snap  <= '0;
        end else if (take) begin
            snap  <= Y_IN;
            idx   <= '0;
            state <= S_DRAIN;
        end else if (xfer) begin
            if (at_last) begin
                state <= S_IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Drop bookkeeping: a drop on the same cycle as a clear wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVF      <= 1'b0;
            DROP_CNT <= '0;
        end else if (drop) begin
            OVF      <= 1'b1;
            DROP_CNT <= CLR_OVF ? 8'd1 :
                        (DROP_CNT == 8'hFF) ? DROP_CNT : DROP_CNT + 8'd1;
        end else if (CLR_OVF) begin
            OVF      <= 1'b0;
            DROP_CNT <= '0;
        end
    end

    // Data is forced to zero when idle so a finished snapshot does not linger
    // on the bus.
    assign OUT_VALID = busy;
    assign BUSY      = busy;
    assign OUT_IDX   = idx;
    assign OUT_LAST  = busy && at_last;
    assign OUT_DATA  = busy ? elem[idx] : '0;

endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: directed bench for sa_result_drain (WIDTH=8, 2x2 PEs).
// A queue-based model of the expected output stream is checked every cycle,
// alongside hand-computed literal expectations at key points.
module tb_sa_result_drain;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int V  = 2;
    localparam int N  = H * V;
    localparam int DW = 2 * W;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [DW*N-1:0]     y = '0;
    logic                cap = 1'b0;
    logic                clr = 1'b0;
    logic                ready = 1'b1;
    logic [DW-1:0]       out_data;
    logic [1:0]          out_idx;
    logic                out_valid;
    logic                out_last;
    logic                busy;
    logic                ovf;
    logic [7:0]          drop_cnt;

    int total  = 0;
    int passed = 0;
    bit armed  = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        int            idx;
    } item_t;

    item_t q[$];
    bit    m_ovf = 1'b0;
    int    m_cnt = 0;

    sa_result_drain #(.WIDTH(W), .HPE(H), .VPE(V)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Y_IN      (y),
        .CAP       (cap),
        .CLR_OVF   (clr),
        .OUT_DATA  (out_data),
        .OUT_IDX   (out_idx),
        .OUT_VALID (out_valid),
        .OUT_READY (ready),
        .OUT_LAST  (out_last),
        .BUSY      (busy),
        .OVF       (ovf),
        .DROP_CNT  (drop_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: the stream is a queue of pending results; a capture is taken
    // only if nothing remains pending after this cycle's transfer.
    always @(posedge CLK) begin
        if (RST) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            bit dropped;
            dropped = 1'b0;
            if (q.size() > 0 && ready) void'(q.pop_front());
            if (cap) begin
                if (q.size() == 0) begin
                    for (int p = 0; p < N; p++) begin
                        item_t it;
                        it.data = y[(N-1-p)*DW +: DW];
                        it.idx  = p;
                        q.push_back(it);
                    end
                end else begin
                    dropped = 1'b1;
                end
            end
            if (dropped) begin
                m_ovf = 1'b1;
                m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge CLK) begin
        if (armed) begin
            chk("valid", out_valid, q.size() > 0);
            chk("busy", busy, q.size() > 0);
            if (q.size() > 0) begin
                chk("data", out_data, q[0].data);
                chk("idx", out_idx, q[0].idx);
                chk("last", out_last, q[0].idx == N-1);
            end
            chk("ovf", ovf, m_ovf);
            chk("drop_cnt", drop_cnt, m_cnt);
        end
    end

    logic [DW-1:0] basic_w [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [DW-1:0] alt_w   [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cnt", drop_cnt, 0);
        armed = 1'b1;
        RST = 1'b0;

        // Basic drain
        y = 64'h0001_0002_0003_0004; cap = 1'b1;
        @(negedge CLK); cap = 1'b0;
        for (int p = 0; p < 4; p++) begin
            chk("basic_data", out_data, basic_w[p]);
            chk("basic_idx", out_idx, p);
            chk("basic_last", out_last, p == 3);
            @(negedge CLK);
        end
        chk("basic_idle", busy, 0);

        // Backpressure, with Y_IN changed after capture
        y = 64'h0001_0002_0003_0004; cap = 1'b1;
        @(negedge CLK); cap = 1'b0; y = 64'hFFFF_EEEE_9999_8888;
        @(negedge CLK); ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_data", out_data, 16'h0002);
            chk("bp_hold_idx", out_idx, 1);
            @(negedge CLK);
        end
        chk("bp_hold_data4", out_data, 16'h0002);
        ready = 1'b1;
        @(negedge CLK); chk("bp_p2", out_data, 16'h0003);
        @(negedge CLK); chk("bp_p3", out_data, 16'h0004); chk("bp_last", out_last, 1);
        @(negedge CLK); chk("bp_idle", busy, 0);

        // Drop during drain, then clear plus simultaneous drop
        y = 64'h0001_0002_0003_0004; cap = 1'b1;
        @(negedge CLK); cap = 1'b0;
        @(negedge CLK);
        @(negedge CLK); chk("drop_at_idx", out_idx, 2);
        cap = 1'b1; y = 64'h1111_2222_3333_4444;
        @(negedge CLK); cap = 1'b0;
        chk("drop_stream", out_data, 16'h0004);
        chk("drop_ovf", ovf, 1);
        chk("drop_cnt1", drop_cnt, 1);
        ready = 1'b0; cap = 1'b1; clr = 1'b1;
        @(negedge CLK); cap = 1'b0; clr = 1'b0;
        chk("clrdrop_ovf", ovf, 1);
        chk("clrdrop_cnt", drop_cnt, 1);
        clr = 1'b1;
        @(negedge CLK); clr = 1'b0;
        chk("clr_ovf", ovf, 0);
        chk("clr_cnt", drop_cnt, 0);
        ready = 1'b1;
        @(negedge CLK); chk("drop_idle", busy, 0);

        // Back-to-back capture on the final transfer
        y = 64'h0001_0002_0003_0004; cap = 1'b1;
        @(negedge CLK); cap = 1'b0;
        repeat (3) @(negedge CLK);
        chk("b2b_pre_last", out_data, 16'h0004);
        y = 64'hAAAA_BBBB_CCCC_DDDD; cap = 1'b1;
        @(negedge CLK); cap = 1'b0;
        for (int p = 0; p < 4; p++) begin
            chk("b2b_valid", out_valid, 1);
            chk("b2b_data", out_data, alt_w[p]);
            chk("b2b_idx", out_idx, p);
            chk("b2b_ovf", ovf, 0);
            @(negedge CLK);
        end
        chk("b2b_idle", busy, 0);

        // Reset mid-drain, with CAP held during reset (ignored)
        y = 64'h0001_0002_0003_0004; cap = 1'b1;
        @(negedge CLK); cap = 1'b0;
        @(negedge CLK); chk("rstmid_idx", out_idx, 1);
        RST = 1'b1; cap = 1'b1;
        @(negedge CLK); RST = 1'b0; cap = 1'b0;
        chk("rstmid_data", out_data, 0);
        chk("rstmid_idx0", out_idx, 0);
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_last", out_last, 0);
        chk("rstmid_busy", busy, 0);
        y = 64'hAAAA_BBBB_CCCC_DDDD; cap = 1'b1;
        @(negedge CLK); cap = 1'b0;
        chk("restart_data", out_data, 16'hAAAA);
        chk("restart_idx", out_idx, 0);
        repeat (4) @(negedge CLK);
        chk("restart_idle", busy, 0);

        // Saturation: 300 drops while stalled
        y = 64'h0001_0002_0003_0004; cap = 1'b1;
        @(negedge CLK); ready = 1'b0;
        for (int k = 0; k < 300; k++) @(negedge CLK);
        cap = 1'b0;
        chk("sat_cnt", drop_cnt, 255);
        chk("sat_ovf", ovf, 1);
        chk("sat_hold", out_data, 16'h0001);
        ready = 1'b1;
        repeat (5) @(negedge CLK);
        clr = 1'b1;
        @(negedge CLK); clr = 1'b0;
        chk("sat_clr_cnt", drop_cnt, 0);
        chk("sat_clr_ovf", ovf, 0);

        @(negedge CLK);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sa_result_drain.md
# sa_result_drain

Output drain stage placed directly downstream of the systolic array. On a capture strobe it snapshots the array's full packed result bus (HPE×VPE accumulators, 2·WIDTH bits each) and streams the results out one per cycle over a valid/ready interface, tagged with the flattened PE index. The array can keep computing while a snapshot drains. Captures that arrive while a drain is in progress are dropped and counted.

## Interface
- WIDTH, 8, operand width; each result is 2·WIDTH bits.
- HPE, 4, horizontal PE count.
- VPE, 4, vertical PE count; N = HPE·VPE results per snapshot.
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- Y_IN  in  2·WIDTH·N  packed array result bus, same packing as the array output Y.
- CAP  in  1  capture strobe, single-cycle.
- CLR_OVF  in  1  clears OVF and DROP_CNT.
- OUT_DATA  out  2·WIDTH  current result.
- OUT_IDX  out  $clog2(N)  flattened PE index p of OUT_DATA.
- OUT_VALID  out  1  OUT_DATA/OUT_IDX valid.
- OUT_READY  in  1  consumer accepts.
- OUT_LAST  out  1  high with element p = N-1.
- BUSY  out  1  drain in progress; equals OUT_VALID.
- OVF  out  1  sticky: at least one capture dropped.
- DROP_CNT  out  8  saturating count of dropped captures.

## Operation
- Packing: element p (0..N-1) of Y_IN sits at bits [(N-p)·2W-1 : (N-p-1)·2W], so p=0 is the MSB word. Row = p / VPE, col = p % VPE. Software decodes row and col; the block only emits p.
- State IDLE:
  - OUT_VALID=0.
  - CAP=1 registers Y_IN into the snapshot, sets idx=0 and moves to DRAIN.
- State DRAIN:
  - OUT_VALID=1, OUT_DATA = snapshot[idx], OUT_IDX = idx, OUT_LAST = (idx==N-1).
  - A transfer occurs on a cycle with OUT_VALID && OUT_READY.
  - On a transfer with idx<N-1: idx increments.
  - On a transfer with idx==N-1: go to IDLE, unless CAP=1 on the same cycle. In that case Y_IN is captured, idx=0 and the state stays DRAIN (back-to-back, no bubble).
  - CAP=1 on any other DRAIN cycle: the capture is dropped. Snapshot and idx are unchanged, OVF←1, DROP_CNT←min(DROP_CNT+1, 255).
- Backpressure: while OUT_VALID && !OUT_READY, OUT_DATA, OUT_IDX and OUT_LAST hold stable.
- CLR_OVF=1 clears OVF to 0 and DROP_CNT to 0. If a drop happens on the same cycle, the drop wins: OVF=1, DROP_CNT=1.
- Snapshot is a plain register copy; no arithmetic or truncation is applied to results.

## Timing
- Reset (RST=1 at an edge): state IDLE, idx=0, snapshot=0, OUT_DATA=0, OUT_IDX=0, OUT_VALID=0, OUT_LAST=0, BUSY=0, OVF=0, DROP_CNT=0.
- Reset mid-drain aborts the drain immediately. Remaining elements are discarded and never emitted.
- CAP sampled at edge t → OUT_VALID=1 with p=0 after edge t, i.e. 1-cycle latency.
- With OUT_READY held high, element p is presented in cycle t+1+p. OUT_LAST is presented in cycle t+N. BUSY=0 from cycle t+N+1 unless a back-to-back capture occurred.
- Throughput: one result per cycle; N cycles per snapshot without stalls.
- The snapshot is Y_IN as sampled at the CAP edge. Later changes to Y_IN never affect the values being drained.
- CAP is ignored while RST=1.

## Test plan
- **Basic drain.** WIDTH=8, HPE=VPE=2; Y_IN=64'h0001_0002_0003_0004; CAP one cycle; READY=1 → OUT_DATA 0x0001, 0x0002, 0x0003, 0x0004 with OUT_IDX 0..3 on consecutive cycles starting 1 cycle after CAP. OUT_LAST is high only with 0x0004; BUSY falls after that.
- **Backpressure.** Same setup; READY=0 for 3 cycles while OUT_IDX=1 → OUT_DATA holds 0x0002 for 4 cycles total; the sequence then completes unaltered. Changing Y_IN after CAP has no effect on the output.
- **Drop during drain.** CAP pulse while OUT_IDX=2 → output stream unchanged, OVF=1, DROP_CNT=1. Then CLR_OVF plus a simultaneous drop → OVF=1, DROP_CNT=1.
- **Back-to-back capture.** Second CAP with Y_IN=64'hAAAA_BBBB_CCCC_DDDD on the cycle 0x0004 transfers → next cycle presents 0xAAAA with idx 0. OUT_VALID never drops; OVF stays 0.
- **Reset mid-drain.** RST at OUT_IDX=1 → next cycle all outputs are zero and state is IDLE. A new CAP restarts the drain from idx 0.
- **Saturation.** 300 drops during a drain stalled by READY=0 → DROP_CNT=255, OVF=1.
